instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage that sits directly upstream of the instruction memory. It owns the program counter and drives it to the combinational instruction ROM. It captures the returned word into a single-entry fetch slot and hands it to decode over a valid/ready handshake. Unconditional `j` is predecoded locally with zero penalty; `beq`/`jalr` outcomes arrive later from execute as a redirect.

## Interface
- `RESET_PC`, default 32'h0: PC value loaded on reset.
- `clk`  in  1: single clock; all state changes on rising edge.
- `rst_n`  in  1: reset is synchronous and active-low.
- `imem_pc`  out  32: PC driven to the instruction memory; equals internal `pc_q`.
- `imem_instr`  in  32: instruction word returned combinationally for `imem_pc`, valid in the same cycle.
- `id_valid`  out  1: fetch slot holds an instruction for decode.
- `id_ready`  in  1: decode accepts the slot this cycle.
- `id_instr`  out  32: captured instruction.
- `id_pc`  out  32: PC of the captured instruction.
- `id_pc_plus4`  out  32: `id_pc + 4`, for link/branch use downstream.
- `ex_redirect`  in  1: execute resolved a taken `beq` or a `jalr`.
- `ex_target`  in  32: new PC when `ex_redirect` is 1.
- `halt_req`  in  1: stop fetching; level or pulse, sampled each cycle.
- `halted`  out  1: fetch stopped and slot drained.

## Operation
- FSM states:
  - IDLE: first cycle after reset. No capture; lets the memory see `RESET_PC` for a full cycle.
  - RUN: normal fetch.
  - DRAIN: halt requested, waiting for slot consumption.
  - HALTED: terminal until reset.
- Transitions:
  - IDLE→RUN unconditionally.
  - RUN→DRAIN on `halt_req`.
  - DRAIN→HALTED when the slot is free (`!id_valid`, or `id_valid && id_ready`).
  - HALTED holds.
- Slot free condition: `slot_free = !id_valid || id_ready`.
- RUN, per-edge priority:
  1. `ex_redirect`: `pc_q <= ex_target`; `id_valid <= 0` (flush, even if `id_ready`). The word at old `pc_q` is discarded.
  2. Otherwise, if `slot_free`: capture `id_instr <= imem_instr`, `id_pc <= pc_q`, `id_pc_plus4 <= pc_q+4`, `id_valid <= 1`. Then `pc_q <= next_pc`.
  3. Otherwise (stall): `pc_q` and slot hold.
- `next_pc` rules:
  - If `imem_instr[31:26] == 6'b000111` (j): `{pc_q_plus4[31:28], imem_instr[25:0], 2'b00}`.
  - Otherwise: `pc_q + 4`.
- Arithmetic: all PC arithmetic is 32-bit modulo 2^32; `32'hFFFFFFFC + 4` wraps to 0. No alignment check; bits [1:0] pass through unmodified.
- `halt_req` in the same cycle as `ex_redirect`: redirect applies to `pc_q` and slot, and the state still goes to DRAIN.
- DRAIN/HALTED behaviour:
  - No new captures.
  - `id_valid` clears only on consumption or redirect.
  - `ex_redirect` still updates `pc_q` and flushes the slot.
- `halted` = 1 exactly in HALTED.
- Reset (`!rst_n` at an edge, any state, mid-stall included) sets:
  - `pc_q` = `RESET_PC`
  - `id_valid` = 0
  - `id_instr` = 0, `id_pc` = 0, `id_pc_plus4` = 0
  - `halted` = 0
  - state IDLE
- Reset overrides redirect and halt.

## Timing
- `imem_pc` is combinational from `pc_q`; no other output is combinational from any input.
- Fetch latency:
  - Instruction at `pc_q` appears on `id_*` one edge after `pc_q` is presented (in RUN with a free slot).
  - First `id_valid` is at the 2nd rising edge with `rst_n` high.
- Throughput: 1 instruction/cycle while `id_ready` stays 1.
- `j` penalty: 0 cycles; the target is fetched in the cycle after the `j` is captured.
- Redirect penalty: the cycle after `ex_redirect` has `id_valid` = 0 and `imem_pc` = `ex_target`. Target instruction is valid on the following edge.
- Handshake: while `id_valid && !id_ready`, all `id_*` outputs and `imem_pc` are stable.
- `halted` rises one edge after the draining transfer (or immediately next edge if the slot is already empty).

## Test plan
- Reset/stream: `RESET_PC`=0, ROM words 0..31, `id_ready`=1 → `id_valid` low for 2 edges after `rst_n` rises, then `id_pc` = 0,4,8,12… on consecutive cycles, with `id_instr` matching the ROM.
- Stall: `id_ready`=0 for 3 cycles while `id_pc`=8 → `id_pc`=8, `id_instr` and `imem_pc`=12 held; on release, next `id_pc`=12 with no skip or duplicate.
- Jump: word at PC 88 = `{6'b000111, 26'd29}` → `id_pc` sequence 88, 116 with no bubble; `id_pc_plus4` for 88 is 92.
- Redirect: `ex_redirect`=1, `ex_target`=80 while slot holds PC 72 and `id_ready`=0 → next cycle `id_valid`=0, `imem_pc`=80; following cycle `id_pc`=80. Redirect coincident with a `j` in the ROM → `ex_target` wins.
- Halt: `halt_req` pulse while slot full and `id_ready`=0 for 2 cycles → no new captures, `halted`=0 until the transfer, then `halted`=1 next edge and stays 1.
- Reset mid-run / wrap: `rst_n` low for one edge at `pc_q`=40 with `id_valid`=1 → all outputs at reset values next cycle. Redirect to `32'hFFFFFFFC` with a non-jump word → next fetch PC 0.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction memory port, decode handshake, execute redirect and halt control.
interface instr_fetch_if;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        ex_redirect;
    logic [31:0] ex_target;
    logic        halt_req;
    logic        halted;

    modport master (
        output imem_pc,
        input  imem_instr,
        output id_valid,
        input  id_ready,
        output id_instr,
        output id_pc,
        output id_pc_plus4,
        input  ex_redirect,
        input  ex_target,
        input  halt_req,
        output halted
    );

    modport slave (
        input  imem_pc,
        output imem_instr,
        input  id_valid,
        output id_ready,
        input  id_instr,
        input  id_pc,
        input  id_pc_plus4,
        output ex_redirect,
        output ex_target,
        input  halt_req,
        input  halted
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, predecodes j with zero penalty, holds one fetched word for decode.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input logic           clk,
    input logic           rst_n,
    instr_fetch_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        HALTED
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc_q, pc_n;
    logic [31:0] pc_plus4;
    logic [31:0] fetch_next;
    logic        is_jump;
    logic        slot_free;
    logic        capture;
    logic        slot_valid, slot_valid_n;
    logic [31:0] slot_instr;
    logic [31:0] slot_pc;
    logic [31:0] slot_pc_plus4;

    always_comb begin
        pc_plus4     = pc_q + 32'd4;
        is_jump      = (bus.imem_instr[31:26] == 6'b000111);
        fetch_next   = is_jump ? {pc_plus4[31:28], bus.imem_instr[25:0], 2'b00} : pc_plus4;
        slot_free    = !slot_valid || bus.id_ready;

        state_n      = state;
        pc_n         = pc_q;
        slot_valid_n = slot_valid;
        capture      = 1'b0;

        case (state)
            IDLE: begin
                state_n = RUN;
            end
            RUN: begin
                if (bus.ex_redirect) begin
                    pc_n         = bus.ex_target;
                    slot_valid_n = 1'b0;
                end else if (slot_free) begin
                    capture      = 1'b1;
                    slot_valid_n = 1'b1;
                    pc_n         = fetch_next;
                end
                if (bus.halt_req) begin
                    state_n = DRAIN;
                end
            end
            DRAIN, HALTED: begin
                // No captures once halting; the slot only empties by consumption or flush.
                if (bus.ex_redirect) begin
                    pc_n         = bus.ex_target;
                    slot_valid_n = 1'b0;
                end else if (slot_valid && bus.id_ready) begin
                    slot_valid_n = 1'b0;
                end
                if (state == DRAIN && slot_free) begin
                    state_n = HALTED;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            pc_q          <= RESET_PC;
            slot_valid    <= 1'b0;
            slot_instr    <= '0;
            slot_pc       <= '0;
            slot_pc_plus4 <= '0;
        end else begin
            state      <= state_n;
            pc_q       <= pc_n;
            slot_valid <= slot_valid_n;
            if (capture) begin
                slot_instr    <= bus.imem_instr;
                slot_pc       <= pc_q;
                slot_pc_plus4 <= pc_plus4;
            end
        end
    end

    assign bus.imem_pc     = pc_q;
    assign bus.id_valid    = slot_valid;
    assign bus.id_instr    = slot_instr;
    assign bus.id_pc       = slot_pc;
    assign bus.id_pc_plus4 = slot_pc_plus4;
    assign bus.halted      = (state == HALTED);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: ROM model, transfer scoreboard and point checks.
module tb_instr_fetch;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    logic [31:0] rom [64];
    logic [31:0] exp_q [$];

    instr_fetch_if dut_if ();

    instr_fetch #(.RESET_PC(32'h0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dut_if.master)
    );

    assign dut_if.imem_instr = rom[dut_if.imem_pc[7:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scores any transfer about to happen at the coming edge, then advances one cycle.
    task automatic tick();
        logic [31:0] e;
        if (rst_n && dut_if.id_valid && dut_if.id_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL xfer_extra observed_pc=%h expected=none", dut_if.id_pc);
            end else begin
                e = exp_q.pop_front();
                chk("xfer_pc", dut_if.id_pc, e);
                chk("xfer_instr", dut_if.id_instr, rom[e[7:2]]);
                chk("xfer_pc4", dut_if.id_pc_plus4, e + 32'd4);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 64; i++) begin
            rom[i] = 32'hA500_0000 | (i << 8) | i;
        end
        rom[22] = {6'b000111, 26'd29};
        rom[24] = {6'b000111, 26'd5};

        rst_n              = 1'b0;
        dut_if.id_ready    = 1'b1;
        dut_if.ex_redirect = 1'b0;
        dut_if.ex_target   = '0;
        dut_if.halt_req    = 1'b0;
        tick();
        tick();
        chk("rst_valid", {31'd0, dut_if.id_valid}, 32'd0);
        chk("rst_imem_pc", dut_if.imem_pc, 32'd0);
        chk("rst_halted", {31'd0, dut_if.halted}, 32'd0);
        chk("rst_id_pc", dut_if.id_pc, 32'd0);
        chk("rst_id_instr", dut_if.id_instr, 32'd0);

        // Reset release and streaming
        rst_n = 1'b1;
        for (int a = 0; a <= 88; a += 4) exp_q.push_back(a);
        tick();
        chk("idle_valid", {31'd0, dut_if.id_valid}, 32'd0);
        tick();
        chk("first_valid", {31'd0, dut_if.id_valid}, 32'd1);
        chk("first_pc", dut_if.id_pc, 32'd0);
        chk("first_instr", dut_if.id_instr, rom[0]);
        tick();
        chk("stream_pc4", dut_if.id_pc, 32'd4);
        tick();
        chk("stream_pc8", dut_if.id_pc, 32'd8);
        chk("stream_imem12", dut_if.imem_pc, 32'd12);

        // Stall
        dut_if.id_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_pc", dut_if.id_pc, 32'd8);
            chk("stall_instr", dut_if.id_instr, rom[2]);
            chk("stall_imem", dut_if.imem_pc, 32'd12);
            chk("stall_valid", {31'd0, dut_if.id_valid}, 32'd1);
        end
        dut_if.id_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("run_pc", dut_if.id_pc, 32'd12 + 32'(4 * k));
        end

        // Jump at 88
        chk("j_pc4", dut_if.id_pc_plus4, 32'd92);
        chk("j_imem", dut_if.imem_pc, 32'd116);
        tick();
        chk("j_target_pc", dut_if.id_pc, 32'd116);
        chk("j_target_valid", {31'd0, dut_if.id_valid}, 32'd1);

        // Redirects
        dut_if.id_ready    = 1'b0;
        dut_if.ex_redirect = 1'b1;
        dut_if.ex_target   = 32'd72;
        tick();
        chk("redir72_valid", {31'd0, dut_if.id_valid}, 32'd0);
        chk("redir72_imem", dut_if.imem_pc, 32'd72);
        dut_if.ex_redirect = 1'b0;
        tick();
        chk("slot72_pc", dut_if.id_pc, 32'd72);
        dut_if.ex_redirect = 1'b1;
        dut_if.ex_target   = 32'd80;
        tick();
        chk("redir80_valid", {31'd0, dut_if.id_valid}, 32'd0);
        chk("redir80_imem", dut_if.imem_pc, 32'd80);
        dut_if.ex_redirect = 1'b0;
        dut_if.id_ready    = 1'b1;
        exp_q.push_back(32'd80);
        tick();
        chk("slot80_pc", dut_if.id_pc, 32'd80);
        chk("slot80_valid", {31'd0, dut_if.id_valid}, 32'd1);
        tick();
        chk("slot84_pc", dut_if.id_pc, 32'd84);
        dut_if.id_ready    = 1'b0;
        dut_if.ex_redirect = 1'b1;
        dut_if.ex_target   = 32'd96;
        tick();
        chk("redir96_imem", dut_if.imem_pc, 32'd96);
        dut_if.ex_target = 32'd200;
        tick();
        chk("redir_over_j_imem", dut_if.imem_pc, 32'd200);
        chk("redir_over_j_valid", {31'd0, dut_if.id_valid}, 32'd0);
        dut_if.ex_redirect = 1'b0;
        tick();
        chk("slot200_pc", dut_if.id_pc, 32'd200);
        chk("slot200_imem", dut_if.imem_pc, 32'd204);

        // Halt while stalled
        dut_if.halt_req = 1'b1;
        tick();
        chk("drain1_halted", {31'd0, dut_if.halted}, 32'd0);
        chk("drain1_pc", dut_if.id_pc, 32'd200);
        chk("drain1_imem", dut_if.imem_pc, 32'd204);
        dut_if.halt_req = 1'b0;
        tick();
        chk("drain2_halted", {31'd0, dut_if.halted}, 32'd0);
        chk("drain2_valid", {31'd0, dut_if.id_valid}, 32'd1);
        dut_if.id_ready = 1'b1;
        exp_q.push_back(32'd200);
        tick();
        chk("halt_halted", {31'd0, dut_if.halted}, 32'd1);
        chk("halt_valid", {31'd0, dut_if.id_valid}, 32'd0);
        chk("halt_imem", dut_if.imem_pc, 32'd204);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("halt_hold", {31'd0, dut_if.halted}, 32'd1);
            chk("halt_nocap", {31'd0, dut_if.id_valid}, 32'd0);
        end

        // Reset mid-run
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int a = 0; a <= 32; a += 4) exp_q.push_back(a);
        for (int k = 0; k < 11; k++) tick();
        chk("mid_imem", dut_if.imem_pc, 32'd40);
        chk("mid_valid", {31'd0, dut_if.id_valid}, 32'd1);
        chk("mid_pc", dut_if.id_pc, 32'd36);
        rst_n = 1'b0;
        tick();
        chk("mrst_valid", {31'd0, dut_if.id_valid}, 32'd0);
        chk("mrst_imem", dut_if.imem_pc, 32'd0);
        chk("mrst_pc", dut_if.id_pc, 32'd0);
        chk("mrst_instr", dut_if.id_instr, 32'd0);
        chk("mrst_pc4", dut_if.id_pc_plus4, 32'd0);
        chk("mrst_halted", {31'd0, dut_if.halted}, 32'd0);

        // PC wrap
        rst_n           = 1'b1;
        dut_if.id_ready = 1'b0;
        tick();
        tick();
        chk("wrap_pre_pc", dut_if.id_pc, 32'd0);
        dut_if.ex_redirect = 1'b1;
        dut_if.ex_target   = 32'hFFFF_FFFC;
        tick();
        chk("wrap_imem_top", dut_if.imem_pc, 32'hFFFF_FFFC);
        dut_if.ex_redirect = 1'b0;
        tick();
        chk("wrap_pc", dut_if.id_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", dut_if.id_pc_plus4, 32'd0);
        chk("wrap_instr", dut_if.id_instr, rom[63]);
        chk("wrap_imem", dut_if.imem_pc, 32'd0);

        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
